// File: rtl/pipelined_sticky_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_sticky_shifter
// Brief    : Log2 barrel right shifter with guard/round/sticky output,
//            one register per level, valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_sticky_shifter #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_a,
  input  logic [SHIFT_WIDTH-1:0]  s_b,
  input  logic                    s_arith,
  input  logic [TAG_WIDTH-1:0]    s_tag,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH+2:0]   m_c,
  output logic [TAG_WIDTH-1:0]    m_tag
);

  localparam int c_w = DATA_WIDTH + 3;

  // Index k is the input of level k; index SHIFT_WIDTH is the output stage.
  logic                   w_valid [SHIFT_WIDTH+1];
  logic [c_w-1:0]         w_data  [SHIFT_WIDTH+1];
  logic [TAG_WIDTH-1:0]   w_tag   [SHIFT_WIDTH+1];
  logic [SHIFT_WIDTH-1:0] w_b     [SHIFT_WIDTH];
  logic                   w_fill  [SHIFT_WIDTH];
  logic                   w_adv;

  assign w_valid[0] = s_valid;
  assign w_data[0]  = {s_a, 3'b000};
  assign w_tag[0]   = s_tag;
  assign w_b[0]     = s_b;
  assign w_fill[0]  = s_arith & s_a[DATA_WIDTH-1];

  assign w_adv   = m_ready | ~w_valid[SHIFT_WIDTH];
  assign s_ready = w_adv;
  assign m_valid = w_valid[SHIFT_WIDTH];
  assign m_c     = w_data[SHIFT_WIDTH];
  assign m_tag   = w_tag[SHIFT_WIDTH];

  generate
    for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
      // Steps wider than the word saturate: everything drops into sticky.
      localparam int c_step  = (k >= 30) ? c_w : (1 << k);
      localparam int c_shift = (c_step >= c_w) ? c_w : c_step;
      localparam int c_keep  = (c_shift >= c_w - 1) ? 0 : (c_w - 1 - c_shift);
      localparam logic [c_w-1:0] c_mask = {c_w{1'b1}} >> c_keep;

      logic [c_w-2:0]       w_hi;
      logic [c_w-1:0]       w_lvl;
      logic                 r_valid;
      logic [c_w-1:0]       r_data;
      logic [TAG_WIDTH-1:0] r_tag;

      // Bits landing on or below position 0 (including old sticky) fold into bit 0.
      assign w_hi  = (c_w-1)'({{c_w{w_fill[k]}}, w_data[k]} >> (c_shift + 1));
      assign w_lvl = w_b[k][k] ? {w_hi, |(w_data[k] & c_mask)} : w_data[k];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_tag   <= '0;
        end else if (w_adv) begin
          r_valid <= w_valid[k];
          if (w_valid[k]) begin
            r_data <= w_lvl;
            r_tag  <= w_tag[k];
          end
        end
      end

      assign w_valid[k+1] = r_valid;
      assign w_data[k+1]  = r_data;
      assign w_tag[k+1]   = r_tag;

      if (k < SHIFT_WIDTH - 1) begin : g_side
        logic [SHIFT_WIDTH-1:0] r_b;
        logic                   r_fill;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_b    <= '0;
            r_fill <= 1'b0;
          end else if (w_adv && w_valid[k]) begin
            r_b    <= w_b[k];
            r_fill <= w_fill[k];
          end
        end

        assign w_b[k+1]    = r_b;
        assign w_fill[k+1] = r_fill;
      end
    end
  endgenerate

endmodule
`default_nettype wire
